// File: rtl/debounce_pkg.sv
// Shared width helpers and types for the debounce_bank push-button conditioner.
package debounce_pkg;

  typedef enum logic {
    REP_FIRST,
    REP_NEXT
  } rep_phase_t;

  // $clog2 clamped to at least one bit so degenerate parameters still give legal vectors.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 32'd2) ? 32'd1 : $clog2(v);
  endfunction

  function automatic int unsigned tick_w(input int unsigned tick_div);
    return clog2_min1(tick_div);
  endfunction

  function automatic int unsigned stab_w(input int unsigned stable_ticks);
    return clog2_min1(stable_ticks);
  endfunction

  function automatic int unsigned rep_w(input int unsigned delay, input int unsigned rate);
    return clog2_min1(((delay > rate) ? delay : rate) + 32'd1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, tick-sampled stability filter, press/release strobes and,
// with DEBOUNCE_REPEAT_EN defined, an auto-repeat strobe while held.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic pressed,
  output logic released,
  output logic held
);

  localparam int unsigned SW = stab_w(STABLE_TICKS);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);

  logic          s1;
  logic          s2;
  logic [SW-1:0] stab_cnt;
  logic          commit;

  assign commit = tick && (s2 != level) && (stab_cnt == STAB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stab_cnt <= '0;
      level    <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      pressed  <= 1'b0;
      released <= 1'b0;
      if (tick) begin
        if (s2 == level) begin
          stab_cnt <= '0;
        end else if (commit) begin
          level    <= s2;
          stab_cnt <= '0;
          pressed  <= s2;
          released <= ~s2;
        end else begin
          stab_cnt <= stab_cnt + SW'(1);
        end
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned RW = rep_w(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [RW-1:0] FIRST_AT = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] NEXT_AT  = RW'(REPEAT_RATE);

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_inc;
  logic [RW-1:0] rep_target;
  rep_phase_t    rep_phase;

  always_comb begin
    rep_inc    = rep_cnt + RW'(1);
    rep_target = (rep_phase == REP_FIRST) ? FIRST_AT : NEXT_AT;
  end

  // Any commit clears the repeat state: a press restarts the delay, a release suppresses held.
  always_ff @(posedge clk) begin
    if (rst || !level || commit) begin
      rep_cnt   <= '0;
      rep_phase <= REP_FIRST;
      held      <= 1'b0;
    end else begin
      held <= 1'b0;
      if (tick) begin
        if (rep_inc == rep_target) begin
          held      <= 1'b1;
          rep_cnt   <= '0;
          rep_phase <= REP_NEXT;
        end else begin
          rep_cnt <= rep_inc;
        end
      end
    end
  end
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign held = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner with one shared sample-tick divider.
// Auto-repeat on held buttons is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS     = 5,
  parameter int unsigned TICK_DIV     = 125000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] held
);

  localparam int unsigned TW = tick_w(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .raw     (raw[i]),
      .level   (level[i]),
      .pressed (pressed[i]),
      .released(released[i]),
      .held    (held[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed and randomized checks of debounce_bank against a sample-window reference model.
module tb_debounce_bank;
  localparam int unsigned CH = 2;
  localparam int unsigned TD = 4;
  localparam int unsigned ST = 3;
  localparam int unsigned RD = 5;
  localparam int unsigned RR = 2;
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] raw = '0;
  logic [CH-1:0] level, pressed, released, held;

  debounce_bank #(
    .CHANNELS(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .raw(raw),
    .level(level), .pressed(pressed), .released(released), .held(held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: raw delay line, per-channel window of recent tick samples, ticks held.
  int            cyc;
  logic [CH-1:0] rawq[$];
  bit            win[CH][$];
  int            reps[CH];
  logic [CH-1:0] m_lev, e_pr, e_rl, e_hd;
  logic          e_tick;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_edge(input logic r, input logic [CH-1:0] rw);
    logic [CH-1:0] samp;
    bit            is_tick;
    bit            all_dis;
    e_pr = '0; e_rl = '0; e_hd = '0;
    if (r) begin
      cyc   = 0;
      m_lev = '0;
      rawq  = {CH'(0), CH'(0)};
      for (int c = 0; c < CH; c++) begin
        win[c].delete();
        reps[c] = 0;
      end
    end else begin
      samp = rawq.pop_front();
      rawq.push_back(rw);
      is_tick = ((cyc % TD) == TD - 1);
      if (is_tick) begin
        for (int c = 0; c < CH; c++) begin
          win[c].push_back(samp[c]);
          if (win[c].size() > ST) void'(win[c].pop_front());
          all_dis = (win[c].size() == ST);
          for (int k = 0; k < win[c].size(); k++)
            if (win[c][k] == m_lev[c]) all_dis = 1'b0;
          if (all_dis) begin
            m_lev[c] = samp[c];
            win[c].delete();
            if (samp[c]) begin
              e_pr[c] = 1'b1;
              reps[c] = 0;
            end else begin
              e_rl[c] = 1'b1;
            end
          end else if (m_lev[c]) begin
            reps[c]++;
            if (reps[c] == RD || (reps[c] > RD && ((reps[c] - RD) % RR) == 0))
              e_hd[c] = REP_ON;
          end
        end
      end
      cyc++;
    end
    e_tick = ((cyc % TD) == TD - 1);
  endtask

  task automatic step(input logic r, input logic [CH-1:0] rw);
    rst = r;
    raw = rw;
    @(posedge clk);
    model_edge(r, rw);
    #1;
    chk("level", 32'(level), 32'(m_lev));
    chk("pressed", 32'(pressed), 32'(e_pr));
    chk("released", 32'(released), 32'(e_rl));
    chk("held", 32'(held), 32'(e_hd));
    chk("tick", 32'(dut.tick), 32'(e_tick));
  endtask

  initial begin
    int cnt, cnt2, lat, rise;
    logic [CH-1:0] rv;
    int hold[CH];

    step(1'b1, '0);
    step(1'b1, '0);
    chk("reset_outs", 32'({level, pressed, released, held}), 32'd0);

    // Tick wrap: ticks in cycles 3, 7, 11 after reset release.
    cnt = 0;
    for (int n = 0; n < 3 * TD; n++) begin
      step(1'b0, '0);
      if (dut.tick) cnt++;
    end
    chk("tick_count", 32'(cnt), 32'd3);

    // Glitch: two tick samples high never commits.
    cnt = 0;
    for (int n = 0; n < 2 * TD; n++) begin
      step(1'b0, 2'b01);
      cnt += int'(level[0]) + int'(pressed[0]) + int'(released[0]);
    end
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 2'b00);
      cnt += int'(level[0]) + int'(pressed[0]) + int'(released[0]);
    end
    chk("glitch_quiet", 32'(cnt), 32'd0);

    // Clean press on channel 0.
    cnt = 0; lat = -1;
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 2'b01);
      if (pressed[0]) cnt++;
      if (lat < 0 && level[0]) lat = n + 1;
    end
    chk("press_seen", 32'(lat > 0), 32'd1);
    chk("press_latency", 32'(lat <= 2 + ST * TD), 32'd1);
    chk("press_once", 32'(cnt), 32'd1);
    chk("ch1_idle", 32'({level[1], pressed[1], released[1]}), 32'd0);

    // Release on channel 0.
    cnt = 0; cnt2 = 0;
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 2'b00);
      if (released[0]) cnt++;
      if (pressed[0]) cnt2++;
    end
    chk("release_once", 32'(cnt), 32'd1);
    chk("release_no_press", 32'(cnt2), 32'd0);
    chk("release_level", 32'(level[0]), 32'd0);

    // Auto-repeat on channel 1 for 20 ticks after the press commit.
    lat = 0;
    while (!level[1] && lat < 30) begin
      step(1'b0, 2'b10);
      lat++;
    end
    chk("rep_press_seen", 32'(level[1]), 32'd1);
    cnt = 0;
    for (int n = 0; n < 20 * TD; n++) begin
      step(1'b0, 2'b10);
      if (held[1]) cnt++;
    end
    chk("repeat_count", 32'(cnt), REP_ON ? 32'd8 : 32'd0);
    for (int n = 0; n < 20; n++) step(1'b0, 2'b00);

    // Reset after two disagreeing samples on channel 0.
    lat = 0;
    while (!(win[0].size() >= 2 && win[0][$] == 1'b1 && win[0][$-1] == 1'b1) && lat < 40) begin
      step(1'b0, 2'b01);
      lat++;
    end
    chk("rst_pre_level", 32'(level[0]), 32'd0);
    step(1'b1, 2'b01);
    chk("rst_outs", 32'({level, pressed, released, held}), 32'd0);
    rise = -1;
    for (int n = 0; n < 16; n++) begin
      step(1'b0, 2'b01);
      if (rise < 0 && level[0]) rise = n;
    end
    chk("rst_relatch_cycle", 32'(rise), 32'd11);

    // Randomized runs on both channels.
    rv = '0;
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          rv[c]   = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 18);
        end else begin
          hold[c]--;
        end
      end
      step(1'b0, rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
